sprite_mover: RTL
=================

SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameter W, default 10, width of the position and motion datapath.
REQ-002 Parameters X_MIN/X_MAX/Y_MIN/Y_MAX, defaults 0/639/0/479, inclusive screen bounds.
REQ-003 Parameters X_CENTER/Y_CENTER, defaults 320/240, reset position.
REQ-004 Parameters SIZE, default 16, sprite extent; STEP, default 2, pixels per frame.
REQ-005 frame_clk  in  1  frame-rate clock, the only clock; all state changes on its rising edge.
REQ-006 Reset  in  1  synchronous reset, active-high.
REQ-007 keycode  in  16  two concurrent key bytes, [7:0] and [15:8].
REQ-008 hold_mode  in  1  0 = sprite stops on key release; 1 = sprite keeps its last motion (autonomous).
REQ-009 pos_x, pos_y  out  W  registered top-left position.
REQ-010 dir_x, dir_y  out  2  registered axis state (STOP=0, POS=1, NEG=2).
REQ-011 edge_hit  out  1  one-frame pulse when either axis is clamped at a bound.

Function
REQ-012 Key decode: 0x1A = up (Y NEG), 0x16 = down (Y POS), 0x04 = left (X NEG), 0x07 = right (X POS); a request is active if either key byte matches.
REQ-013 Opposing requests on one axis cancel, leaving no request on that axis; the two axes are independent.
REQ-014 Per-axis FSM states: STOP, POS, NEG; an active request forces the matching state.
REQ-015 With no request: hold_mode=0 -> STOP; hold_mode=1 -> remain in the current state.
REQ-016 Next position is computed from the next-state motion of the same edge, so a key press moves the sprite on the first frame_clk edge it is sampled (latency 1 frame).
REQ-017 Motion is +STEP (POS), -STEP (NEG) or 0 (STOP); arithmetic is W+1 bits signed; no wrap-around.
REQ-018 Legal range is [MIN, MAX-SIZE]; a next position outside it is clamped to the violated bound.
REQ-019 A clamp asserts edge_hit for exactly that frame.
REQ-020 At a clamp with a key held toward the bound, position stays at the bound and the state stays in that direction.
REQ-021 At a clamp with no key on that axis, the state is set by REQ-030 / REQ-031.
REQ-022 Parameter legality, checked at elaboration: MIN < MAX-SIZE; 1 <= STEP <= MAX-SIZE-MIN; CENTER lies in the legal range.

Reset
REQ-023 Reset has priority over all other inputs.
REQ-024 Reset values: pos_x=X_CENTER, pos_y=Y_CENTER, dir_x=dir_y=STOP, edge_hit=0.
REQ-025 Reset asserted mid-motion takes effect at the next frame_clk edge; motion resumes only from keycode sampled after Reset deasserts.

Configuration
REQ-030 Macro SPRITE_MOVER_BOUNCE_EN defined: a clamp without a key on that axis reverses that axis state (POS<->NEG).
REQ-031 Macro SPRITE_MOVER_BOUNCE_EN undefined: a clamp sets that axis to STOP; there is no bounce logic.

Structure
REQ-032 Package sprite_pkg holds the key-code constants, the dir_t enum (STOP/POS/NEG) and the default bound constants.
REQ-033 Sub-module sprite_axis (one FSM, motion, clamp, edge flag) is instantiated twice, for X and Y.
REQ-034 Top-level sprite_mover contains only key decode, the two sprite_axis instances and the edge_hit OR.

Verification (defaults: SIZE=16, STEP=2)
REQ-040 Reset -> pos (320,240), dir STOP/STOP, edge_hit 0.
REQ-041 keycode=0x0007, hold_mode=0, 10 frames -> pos_x=340; then keycode=0 -> pos_x stays 340, dir_x=STOP.
REQ-042 keycode=0x0704 -> pos_x unchanged; keycode=0x1A07 -> x+2, y-2 per frame.
REQ-043 Right key held from 320 -> 622 after 151 frames, then 623 with edge_hit=1, then 623 held with edge_hit=1 every frame.
REQ-044 hold_mode=1, tap 0x0007 for one frame -> motion continues to 623; BOUNCE_EN: 623 then 621, dir_x=NEG; without BOUNCE_EN: 623 and dir_x=STOP.
REQ-045 Reset pulsed mid-motion at pos_x=400 -> next edge gives (320,240) with STOP.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite mover: key codes, axis state and default screen bounds.
package sprite_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } dir_t;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  localparam int W_DEF        = 10;
  localparam int X_MIN_DEF    = 0;
  localparam int X_MAX_DEF    = 639;
  localparam int Y_MIN_DEF    = 0;
  localparam int Y_MAX_DEF    = 479;
  localparam int X_CENTER_DEF = 320;
  localparam int Y_CENTER_DEF = 240;
  localparam int SIZE_DEF     = 16;
  localparam int STEP_DEF     = 2;

  // A key is pressed if either of the two concurrent key bytes carries its code.
  function automatic logic key_hit(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

endpackage

// File: rtl/sprite_axis.sv
// One motion axis: STOP/POS/NEG state, step, clamp to [MIN, MAX-SIZE] and clamp flag.
// Define SPRITE_MOVER_BOUNCE_EN to reverse direction at a clamp with no key held; otherwise the axis stops.
module sprite_axis
  import sprite_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int MIN    = X_MIN_DEF,
  parameter int MAX    = X_MAX_DEF,
  parameter int CENTER = X_CENTER_DEF,
  parameter int SIZE   = SIZE_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         req_pos,
  input  logic         req_neg,
  input  logic         hold_mode,
  output logic [W-1:0] pos,
  output dir_t         dir,
  output logic         hit
);

  localparam int HI = MAX - SIZE;
  localparam logic signed [W:0] LO_S   = $signed((W+1)'(MIN));
  localparam logic signed [W:0] HI_S   = $signed((W+1)'(HI));
  localparam logic signed [W:0] STEP_S = $signed((W+1)'(STEP));

  if (!(MIN < HI)) begin : g_bad_range
    $error("sprite_axis: MIN must be below MAX-SIZE");
  end
  if (STEP < 1 || STEP > HI - MIN) begin : g_bad_step
    $error("sprite_axis: STEP must lie in 1..MAX-SIZE-MIN");
  end
  if (CENTER < MIN || CENTER > HI) begin : g_bad_center
    $error("sprite_axis: CENTER must lie in [MIN, MAX-SIZE]");
  end
  if (HI + STEP >= 2**W) begin : g_bad_width
    $error("sprite_axis: W too narrow for MAX-SIZE+STEP");
  end

  // Saturate a signed candidate position onto the legal range.
  function automatic logic [W-1:0] sat_pos(input logic signed [W:0] v);
    if (v < LO_S)      return LO_S[W-1:0];
    else if (v > HI_S) return HI_S[W-1:0];
    else               return v[W-1:0];
  endfunction

  dir_t                dir_m;
  dir_t                dir_n;
  logic signed [W:0]   motion;
  logic signed [W:0]   sum;
  logic                clamp;
  logic        [W-1:0] pos_n;

  always_comb begin
    dir_m = STOP;
    if (req_pos)        dir_m = POS;
    else if (req_neg)   dir_m = NEG;
    else if (hold_mode) dir_m = dir;

    // Position follows the state chosen on this same edge, so a key moves the sprite immediately.
    case (dir_m)
      POS:     motion = STEP_S;
      NEG:     motion = -STEP_S;
      default: motion = '0;
    endcase

    sum   = $signed({1'b0, pos}) + motion;
    clamp = (sum < LO_S) || (sum > HI_S);
    pos_n = sat_pos(sum);

    dir_n = dir_m;
    if (clamp && !req_pos && !req_neg) begin
`ifdef SPRITE_MOVER_BOUNCE_EN
      dir_n = (dir_m == POS) ? NEG : POS;
`else
      dir_n = STOP;
`endif
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      pos <= W'(CENTER);
      dir <= STOP;
      hit <= 1'b0;
    end else begin
      pos <= pos_n;
      dir <= dir_n;
      hit <= clamp;
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// Keyboard-driven sprite: decodes two key bytes into per-axis requests and drives an X and a Y axis.
// Define SPRITE_MOVER_BOUNCE_EN to make the sprite bounce off screen edges when no key steers it.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int X_MIN    = X_MIN_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MIN    = Y_MIN_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int X_CENTER = X_CENTER_DEF,
  parameter int Y_CENTER = Y_CENTER_DEF,
  parameter int SIZE     = SIZE_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [15:0]  keycode,
  input  logic         hold_mode,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [1:0]   dir_x,
  output logic [1:0]   dir_y,
  output logic         edge_hit
);

  logic key_up;
  logic key_down;
  logic key_left;
  logic key_right;
  dir_t dir_x_s;
  dir_t dir_y_s;
  logic hit_x;
  logic hit_y;

  // Opposing keys on one axis cancel each other.
  assign key_up    = key_hit(keycode, KEY_UP);
  assign key_down  = key_hit(keycode, KEY_DOWN);
  assign key_left  = key_hit(keycode, KEY_LEFT);
  assign key_right = key_hit(keycode, KEY_RIGHT);

  sprite_axis #(
    .W(W), .MIN(X_MIN), .MAX(X_MAX), .CENTER(X_CENTER), .SIZE(SIZE), .STEP(STEP)
  ) u_axis_x (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .req_pos   (key_right && !key_left),
    .req_neg   (key_left && !key_right),
    .hold_mode (hold_mode),
    .pos       (pos_x),
    .dir       (dir_x_s),
    .hit       (hit_x)
  );

  sprite_axis #(
    .W(W), .MIN(Y_MIN), .MAX(Y_MAX), .CENTER(Y_CENTER), .SIZE(SIZE), .STEP(STEP)
  ) u_axis_y (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .req_pos   (key_down && !key_up),
    .req_neg   (key_up && !key_down),
    .hold_mode (hold_mode),
    .pos       (pos_y),
    .dir       (dir_y_s),
    .hit       (hit_y)
  );

  assign dir_x    = dir_x_s;
  assign dir_y    = dir_y_s;
  assign edge_hit = hit_x | hit_y;

endmodule
